// File: rtl/conv_layer_scheduler.sv
// Layer-pass scheduler for a convolution engine.
// Walks every kernel of a layer: it loads the weight bank, restarts the
// convolution controller, then collects the pixel results into the output
// buffer. Up to three results can wait while the buffer is full; any result
// beyond that is dropped and raises a sticky overflow flag.
module conv_layer_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int KSEL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KSEL_WIDTH-1:0] cfg_num_kernel,
  input  logic [ADDR_WIDTH-1:0] cfg_pix_per_map,
  output logic                  weight_load_req,
  input  logic                  weight_load_ack,
  output logic [KSEL_WIDTH-1:0] weight_bank_sel,
  output logic                  conv_enable,
  output logic                  conv_rst_n,
  input  logic                  kernel_calc_fin,
  input  logic                  out_buf_full,
  output logic                  out_buf_wr_en,
  output logic [ADDR_WIDTH-1:0] out_buf_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // state   | meaning
  // IDLE    | waiting for start
  // LOAD_W  | weight bank load requested, waiting for ack
  // RESTART | convolution controller held in restart for one cycle
  // RUN     | collecting pixel results and writing them out
  // NEXT_K  | kernel finished, pick next kernel or finish
  // DONE    | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE, LOAD_W, RESTART, RUN, NEXT_K, DONE
  } state_t;

  state_t                state;
  logic [KSEL_WIDTH-1:0] cfg_nk;
  logic [ADDR_WIDTH-1:0] cfg_np;
  logic [KSEL_WIDTH-1:0] kidx;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [1:0]            pending;

  logic                  fin_ok;
  logic                  last_wr;
  logic                  issue;
  logic [1:0]            pending_nxt;

  assign weight_bank_sel = kidx;
  assign out_buf_addr    = pix_cnt;

  // Write issue decision; no new write is issued while the kernel's last write is on the bus
  always_comb begin
    fin_ok      = kernel_calc_fin && (pending != 2'd3);
    last_wr     = out_buf_wr_en && (pix_cnt == cfg_np);
    issue       = (state == RUN) && !out_buf_full && ((pending != 2'd0) || fin_ok) && !last_wr;
    pending_nxt = pending + 2'(fin_ok) - 2'(issue);
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cfg_nk          <= '0;
      cfg_np          <= '0;
      kidx            <= '0;
      pix_cnt         <= '0;
      pending         <= '0;
      weight_load_req <= 1'b0;
      conv_enable     <= 1'b0;
      conv_rst_n      <= 1'b1;
      out_buf_wr_en   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      done          <= 1'b0;
      out_buf_wr_en <= 1'b0;
      conv_rst_n    <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_nk          <= cfg_num_kernel;
            cfg_np          <= cfg_pix_per_map;
            kidx            <= '0;
            pix_cnt         <= '0;
            pending         <= '0;
            overflow        <= 1'b0;
            weight_load_req <= 1'b1;
            busy            <= 1'b1;
            state           <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (weight_load_ack) begin
            weight_load_req <= 1'b0;
            conv_rst_n      <= 1'b0;
            state           <= RESTART;
          end
        end
        RESTART: begin
          conv_enable <= !out_buf_full && (pending == 2'd0);
          state       <= RUN;
        end
        RUN: begin
          pending       <= pending_nxt;
          out_buf_wr_en <= issue;
          if (kernel_calc_fin && (pending == 2'd3)) overflow <= 1'b1;
          if (last_wr) begin
            pix_cnt     <= '0;
            conv_enable <= 1'b0;
            state       <= NEXT_K;
          end else begin
            if (out_buf_wr_en) pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
            conv_enable <= !out_buf_full && (pending_nxt == 2'd0);
          end
        end
        NEXT_K: begin
          if (kidx == cfg_nk) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            kidx            <= kidx + KSEL_WIDTH'(1);
            weight_load_req <= 1'b1;
            state           <= LOAD_W;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, 10, output-buffer address width and pixel-count width.
REQ-002 Parameter KSEL_WIDTH, 4, weight-bank select and kernel-count width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a layer pass; accepted only in IDLE.
REQ-006 cfg_num_kernel  input  KSEL_WIDTH  number of kernels minus 1; sampled on accepted start.
REQ-007 cfg_pix_per_map  input  ADDR_WIDTH  output pixels per kernel minus 1; sampled on accepted start.
REQ-008 weight_load_req  output  1  request to load weight bank weight_bank_sel into the kernel array.
REQ-009 weight_load_ack  input  1  single-cycle pulse: weight load complete.
REQ-010 weight_bank_sel  output  KSEL_WIDTH  current kernel index.
REQ-011 conv_enable  output  1  drives the enable input of the convolution layer controller.
REQ-012 conv_rst_n  output  1  active-low synchronous restart of the convolution controller; low for exactly 1 cycle per kernel.
REQ-013 kernel_calc_fin  input  1  single-cycle pulse: one output pixel valid.
REQ-014 out_buf_full  input  1  output buffer cannot accept a write this cycle.
REQ-015 out_buf_wr_en  output  1  output buffer write strobe.
REQ-016 out_buf_addr  output  ADDR_WIDTH  pixel address of the current write.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  single-cycle pulse when the pass completes.
REQ-019 overflow  output  1  sticky error flag; cleared only by reset or an accepted start.

Function
REQ-020 FSM states: IDLE, LOAD_W, RESTART, RUN, NEXT_K, DONE; all outputs registered.
REQ-021 IDLE -> LOAD_W on start; latch cfg values; clear kernel index, pixel counter, pending counter and overflow.
REQ-022 LOAD_W: hold weight_load_req high until the weight_load_ack cycle; on ack drop the request next cycle and go to RESTART.
REQ-023 RESTART: conv_rst_n low for 1 cycle, then go to RUN.
REQ-024 RUN: conv_enable = 1 only when out_buf_full = 0 and pending = 0; otherwise 0.
REQ-025 Pending counter: 2 bits; increments on kernel_calc_fin and decrements on an issued write; a simultaneous increment and decrement leaves it unchanged.
REQ-026 Write rule: out_buf_wr_en is asserted in the cycle after (pending > 0 or kernel_calc_fin) with out_buf_full = 0; a fin with not full and pending = 0 writes with 1-cycle latency.
REQ-027 out_buf_addr = pixel counter; it increments after each write.
REQ-028 A write with pixel counter = cfg_pix_per_map goes to NEXT_K and clears the pixel counter.
REQ-029 A fin arriving when pending = 3: overflow set, fin dropped, counter stays 3.
REQ-030 NEXT_K: if kernel index = cfg_num_kernel go to DONE, else increment the index and go to LOAD_W.
REQ-031 DONE: done high 1 cycle, conv_enable 0, then go to IDLE.
REQ-032 kernel_calc_fin outside RUN is ignored and does not set overflow.
REQ-033 start outside IDLE is ignored.
REQ-034 weight_load_ack outside LOAD_W is ignored.
REQ-035 cfg_num_kernel = 0 or cfg_pix_per_map = 0 is legal and processes exactly 1 kernel or 1 pixel respectively.

Reset
REQ-036 While rst_n = 0, the following hold: state IDLE, all counters 0, weight_load_req 0, weight_bank_sel 0, conv_enable 0, conv_rst_n 1, out_buf_wr_en 0, out_buf_addr 0, busy 0, done 0, overflow 0.
REQ-037 Reset asserted mid-pass aborts immediately with no done pulse; the first post-reset cycle is IDLE.

Verification
REQ-038 Bench must cover: cfg_num_kernel = 1, cfg_pix_per_map = 3, ack 2 cycles after each request, fin every 4 cycles -> 8 writes, addresses 0,1,2,3 twice, weight_bank_sel 0 then 1, 2 conv_rst_n pulses, then done.
REQ-039 Bench must cover: out_buf_full held high for 5 cycles while 2 fins arrive -> conv_enable 0 during the stall, pending = 2, then 2 back-to-back writes after full drops, no overflow.
REQ-040 Bench must cover: 4 fins while full -> overflow = 1 and only 3 writes issued after release.
REQ-041 Bench must cover: cfg_num_kernel = 0, cfg_pix_per_map = 0, a single fin -> 1 write at address 0, then done 2 cycles later.
REQ-042 Bench must cover: rst_n pulsed low during RUN -> all outputs at reset values in the same cycle; a new start then runs the full pass correctly.
REQ-043 Bench must cover: start, stray ack and stray fin pulsed while in IDLE or mid-pass -> no state change and no spurious write.
